// File: rtl/led_serial_driver_pkg.sv
// Shared definitions for the LED serial driver slice.
// - LED_WIDTH   : LED vector width shared with the bound flasher
// - ser_state_t : driver FSM states (idle, shifting bits, latch pulse)
package led_drv_pkg;

  localparam int LED_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_LATCH
  } ser_state_t;

endpackage

// File: rtl/led_serial_driver_if.sv
// Bus between the flasher side and the LED serial driver.
// Signals:
//   led_in    : LED vector (bit i = LED i, 1 = on)
//   refresh   : one-cycle request to resend the current vector
//   ser_clk   : shift clock to the external 595-style register
//   ser_data  : serial data, stable across each ser_clk high phase
//   ser_latch : storage-register latch pulse
//   busy      : driver is transferring a frame
//   done      : one-cycle pulse when a frame has been latched
// Modports: master drives led_in/refresh, slave (the driver) drives the rest.
interface led_serial_driver_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] led_in;
  logic             refresh;
  logic             ser_clk;
  logic             ser_data;
  logic             ser_latch;
  logic             busy;
  logic             done;

  modport master (
    output led_in,
    output refresh,
    input  ser_clk,
    input  ser_data,
    input  ser_latch,
    input  busy,
    input  done
  );

  modport slave (
    input  led_in,
    input  refresh,
    output ser_clk,
    output ser_data,
    output ser_latch,
    output busy,
    output done
  );

endinterface

// File: rtl/led_serial_driver_tick.sv
// Half-period divider for the serial shift clock.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   clr_i  : hold the counter at zero (driver idle)
//   tick_o : high on the last clk cycle of each CLK_DIV-cycle half-period
module led_ser_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = !clr_i && (cnt_q == TERM);

  // Wraps to zero at the terminal count so it never runs past it.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_serial_driver.sv
// LED serial driver: serialises the flasher's LED vector onto a 595-style
// shift register (ser_clk / ser_data / ser_latch). A frame is sent after
// reset, whenever led_in differs from the last frame sent, and on refresh.
// Ports:
//   clk   : system clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : led_serial_driver_if slave modport (led_in, refresh in;
//           ser_clk, ser_data, ser_latch, busy, done out)
// Parameters:
//   WIDTH   : bits per frame (>= 2)
//   CLK_DIV : clk cycles per ser_clk half-period (>= 1)
// Configuration macro:
//   LED_SER_LSB_FIRST_EN : when defined, bit 0 is shifted first;
//                          otherwise bit WIDTH-1 is shifted first.
module led_serial_driver
  import led_drv_pkg::*;
#(
  parameter int WIDTH   = LED_WIDTH,
  parameter int CLK_DIV = 4
) (
  input logic                clk,
  input logic                rst_n,
  led_serial_driver_if.slave bus
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

`ifdef LED_SER_LSB_FIRST_EN
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return v >> 1;
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return v[0];
  endfunction
`else
  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return v << 1;
  endfunction

  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    return v[WIDTH-1];
  endfunction
`endif

  ser_state_t       state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [WIDTH-1:0] shadow_q;
  logic [BW-1:0]    bitcnt_q;
  logic             init_pend_q;
  logic             refresh_pend_q;
  logic             ser_clk_q;
  logic             ser_data_q;
  logic             ser_latch_q;
  logic             busy_q;
  logic             done_q;

  logic             tick;
  logic             start;
  logic             bit_end;

  led_ser_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q == S_IDLE),
    .tick_o (tick)
  );

  assign start = (state_q == S_IDLE) &&
                 (init_pend_q || bus.refresh || refresh_pend_q ||
                  (bus.led_in != shadow_q));

  // End of a ser_clk high phase: the external register has sampled the bit.
  assign bit_end = (state_q == S_SHIFT) && tick && ser_clk_q;

  // Shift data has no reset: it is always loaded before it is used.
  always_comb begin
    shreg_d = shreg_q;
    if (start) begin
      shreg_d = bus.led_in;
    end else if (bit_end && (bitcnt_q != LAST_BIT)) begin
      shreg_d = shift_out(shreg_q);
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      shadow_q       <= '0;
      bitcnt_q       <= '0;
      init_pend_q    <= 1'b1;
      refresh_pend_q <= 1'b0;
      ser_clk_q      <= 1'b0;
      ser_data_q     <= 1'b0;
      ser_latch_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // Any number of refreshes during a frame collapse into one follow-up frame.
      if (bus.refresh && (state_q != S_IDLE)) begin
        refresh_pend_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            shadow_q       <= bus.led_in;
            bitcnt_q       <= '0;
            init_pend_q    <= 1'b0;
            refresh_pend_q <= 1'b0;
            ser_data_q     <= head_bit(bus.led_in);
            busy_q         <= 1'b1;
            state_q        <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (tick) begin
            if (!ser_clk_q) begin
              ser_clk_q <= 1'b1;
            end else begin
              ser_clk_q <= 1'b0;
              if (bitcnt_q == LAST_BIT) begin
                ser_latch_q <= 1'b1;
                state_q     <= S_LATCH;
              end else begin
                ser_data_q <= head_bit(shift_out(shreg_q));
                bitcnt_q   <= bitcnt_q + 1'b1;
              end
            end
          end
        end

        S_LATCH: begin
          if (tick) begin
            ser_latch_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ser_clk   = ser_clk_q;
  assign bus.ser_data  = ser_data_q;
  assign bus.ser_latch = ser_latch_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_led_serial_driver.sv
// Testbench for led_serial_driver (WIDTH=16, CLK_DIV=2).
// Stimulus pushes each expected frame into a queue; a monitor rebuilds
// frames from ser_clk rising edges and checks them when done pulses.
module tb_led_serial_driver;

  localparam int WIDTH   = 16;
  localparam int CLK_DIV = 2;
  localparam int FRAME_LAT = WIDTH * 2 * CLK_DIV + CLK_DIV + 1;

  logic clk;
  logic rst_n;

  led_serial_driver_if #(.WIDTH(WIDTH)) bus ();

  led_serial_driver #(
    .WIDTH   (WIDTH),
    .CLK_DIV (CLK_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- monitor ----------------
  logic [WIDTH-1:0] acc = '0;
  int               nb = 0;
  int               latch_cyc = 0;
  int               serclk_rises = 0;
  logic             ser_clk_prev = 1'b0;
  logic             first_bit = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      acc          = '0;
      nb           = 0;
      latch_cyc    = 0;
      ser_clk_prev = 1'b0;
    end else begin
      if (bus.ser_clk && !ser_clk_prev) begin
        if (nb == 0) first_bit = bus.ser_data;
`ifdef LED_SER_LSB_FIRST_EN
        if (nb < WIDTH) acc[nb] = bus.ser_data;
`else
        acc = {acc[WIDTH-2:0], bus.ser_data};
`endif
        nb++;
        serclk_rises++;
      end
      ser_clk_prev = bus.ser_clk;
      if (bus.ser_latch) latch_cyc++;
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", {16'h0, acc}, 32'hDEAD_BEEF);
        end else begin
          check("frame_data", {16'h0, acc}, {16'h0, exp_q.pop_front()});
        end
        check("frame_bits", nb, WIDTH);
        check("latch_cycles", latch_cyc, CLK_DIV);
        acc       = '0;
        nb        = 0;
        latch_cyc = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_done(input string name, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    while (!got && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (bus.done) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for done after %0d cycles", name, cyc);
    end
  endtask

  task automatic pulse_refresh();
    @(negedge clk);
    bus.refresh = 1'b1;
    @(negedge clk);
    bus.refresh = 1'b0;
  endtask

  task automatic check_idle(input string name, input int cycles);
    int e0;
    e0 = serclk_rises;
    repeat (cycles) @(negedge clk);
    check(name, serclk_rises, e0);
    check({name, "_busy"}, {31'b0, bus.busy}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_ser_clk"},   {31'b0, bus.ser_clk},   32'd0);
    check({name, "_ser_data"},  {31'b0, bus.ser_data},  32'd0);
    check({name, "_ser_latch"}, {31'b0, bus.ser_latch}, 32'd0);
    check({name, "_busy"},      {31'b0, bus.busy},      32'd0);
    check({name, "_done"},      {31'b0, bus.done},      32'd0);
  endtask

  initial begin
    int cyc;
    int guard;

    bus.led_in  = '0;
    bus.refresh = 1'b0;
    rst_n       = 1'b1;
    #1 rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");

    // Reset release: init frame of zeros.
    exp_q.push_back(16'h0000);
    rst_n = 1'b1;
    wait_done("init_frame", cyc);
    check("init_latency", cyc, FRAME_LAT);
    check_idle("init_idle", 20);

    // Change-triggered frame and its latency.
    @(negedge clk);
    bus.led_in = 16'h001F;
    exp_q.push_back(16'h001F);
    wait_done("frame_001F", cyc);
    check("latency_001F", cyc, FRAME_LAT);
    check("first_bit_001F", {31'b0, first_bit}, 32'd0);

    // Unchanged vector: nothing sent; refresh forces a resend.
    check_idle("hold_idle", 200);
    exp_q.push_back(16'h001F);
    pulse_refresh();
    wait_done("refresh_frame", cyc);

    // Changes during a frame: only the latest value follows.
    exp_q.push_back(16'h001F);
    pulse_refresh();
    repeat (10) @(negedge clk);
    bus.led_in = 16'h0007;
    repeat (10) @(negedge clk);
    bus.led_in = 16'h03FF;
    exp_q.push_back(16'h03FF);
    wait_done("busy_frame_a", cyc);
    wait_done("busy_frame_b", cyc);
    check_idle("after_latest_idle", 100);

    // Several refreshes while busy collapse into one extra frame.
    exp_q.push_back(16'h03FF);
    pulse_refresh();
    repeat (5) @(negedge clk);
    pulse_refresh();
    repeat (10) @(negedge clk);
    pulse_refresh();
    exp_q.push_back(16'h03FF);
    wait_done("collapse_a", cyc);
    wait_done("collapse_b", cyc);
    check_idle("collapse_idle", 150);

    // Reset at bit 8: outputs drop at once, partial frame discarded.
    @(negedge clk);
    bus.led_in = 16'hA5C3;
    guard = 0;
    while (nb < 8 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("reached_bit8", {31'b0, (nb >= 8)}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("midreset");
    exp_q.delete();
    repeat (4) @(negedge clk);
    exp_q.push_back(16'hA5C3);
    rst_n = 1'b1;
    wait_done("after_reset_frame", cyc);
    check("after_reset_latency", cyc, FRAME_LAT);

    // Single set bit at position 0 reveals shift order.
    @(negedge clk);
    bus.led_in = 16'h0001;
    exp_q.push_back(16'h0001);
    wait_done("frame_0001", cyc);
`ifdef LED_SER_LSB_FIRST_EN
    check("first_bit_0001", {31'b0, first_bit}, 32'd1);
`else
    check("first_bit_0001", {31'b0, first_bit}, 32'd0);
`endif
    check_idle("final_idle", 50);
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
